// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: HD44780 write-only bus stage. It latches byte/RS, times the setup,
// the EN pulse, the hold and the execution wait, then pulses oDone.
`default_nettype none

module lcd_bus_writer #(
  parameter int SETUP_CYC     = 4,
  parameter int EN_HIGH_CYC   = 16,
  parameter int HOLD_CYC      = 4,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 80000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int MAX_A   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > LONG_EXEC_CYC) ? MAX_C : LONG_EXEC_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Each phase loads N-1 so that it lasts exactly N cycles including the exit edge.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_EXEC_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EN_HI = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             long_exec;
  logic             is_long;
  logic             cnt_zero;

  // Clear display (01) and return home (02/03) need the long execution wait.
  assign is_long  = !iRS && (iDATA == 8'h01 || iDATA == 8'h02 || iDATA == 8'h03);
  assign cnt_zero = (cnt == '0);
  assign LCD_RW   = 1'b0;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      cnt       <= '0;
      long_exec <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= 8'h00;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      case (state)
        // The edge that leaves DONE may also accept, giving back-to-back writes at T+1.
        IDLE, DONE: begin
          oDone <= 1'b0;
          if (iStart) begin
            LCD_DATA  <= iDATA;
            LCD_RS    <= iRS;
            long_exec <= is_long;
            cnt       <= SETUP_LOAD;
            oBusy     <= 1'b1;
            state     <= SETUP;
          end else begin
            oBusy <= 1'b0;
            state <= IDLE;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            LCD_EN <= 1'b1;
            cnt    <= EN_LOAD;
            state  <= EN_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EN_HI: begin
          if (cnt_zero) begin
            LCD_EN <= 1'b0;
            cnt    <= HOLD_LOAD;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            cnt   <= long_exec ? LONG_LOAD : EXEC_LOAD;
            state <= EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EXEC: begin
          if (cnt_zero) begin
            oDone <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          LCD_EN <= 1'b0;
          oBusy  <= 1'b0;
          oDone  <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: directed bench for lcd_bus_writer with short timing parameters.
`default_nettype none

module tb_lcd_bus_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       rs_in;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] lcd_data;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_rs;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_bus_writer #(
    .SETUP_CYC    (2),
    .EN_HIGH_CYC  (3),
    .HOLD_CYC     (2),
    .EXEC_CYC     (5),
    .LONG_EXEC_CYC(20)
  ) dut (
    .iCLK    (clk),
    .iRST    (rst),
    .iDATA   (data_in),
    .iRS     (rs_in),
    .iStart  (start),
    .oBusy   (busy),
    .oDone   (done),
    .LCD_DATA(lcd_data),
    .LCD_RW  (lcd_rw),
    .LCD_EN  (lcd_en),
    .LCD_RS  (lcd_rs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " en"},   32'(lcd_en),   32'd0);
    chk({tag, " rs"},   32'(lcd_rs),   32'd0);
    chk({tag, " data"}, 32'(lcd_data), 32'd0);
    chk({tag, " busy"}, 32'(busy),     32'd0);
    chk({tag, " done"}, 32'(done),     32'd0);
    chk({tag, " rw"},   32'(lcd_rw),   32'd0);
  endtask

  // One transaction; k counts edges after the accept edge t0. Optional input churn.
  task automatic run_txn(input logic [7:0] d, input logic rs, input int t_done,
                         input bit toggle, input string tag);
    data_in = d;
    rs_in   = rs;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= t_done + 1; k++) begin
      chk({tag, " en"},   32'(lcd_en),   32'((k >= 2 && k <= 4) ? 1 : 0));
      chk({tag, " done"}, 32'(done),     32'((k == t_done) ? 1 : 0));
      chk({tag, " busy"}, 32'(busy),     32'((k <= t_done) ? 1 : 0));
      chk({tag, " data"}, 32'(lcd_data), 32'(d));
      chk({tag, " rs"},   32'(lcd_rs),   32'(rs));
      if (toggle) begin
        data_in = ~data_in;
        rs_in   = ~rs_in;
      end
      if (k < t_done + 1) tick();
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    data_in = 8'h41;
    rs_in   = 1'b1;

    // Reset with start asserted: nothing may move.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero("reset");
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all_zero("post_reset");
    end

    run_txn(8'h41, 1'b1, 12, 1'b0, "data_41");
    run_txn(8'h01, 1'b0, 27, 1'b0, "clear_01");
    run_txn(8'h02, 1'b0, 27, 1'b0, "home_02");
    run_txn(8'h03, 1'b0, 27, 1'b0, "home_03");
    run_txn(8'h01, 1'b1, 12, 1'b0, "data_01");
    run_txn(8'h04, 1'b0, 12, 1'b0, "instr_04");
    run_txn(8'h38, 1'b0, 12, 1'b0, "instr_38");

    // Start held high: accepts every 13 cycles, one done per transaction.
    data_in = 8'h30;
    rs_in   = 1'b0;
    start   = 1'b1;
    tick();
    for (int k = 0; k <= 38; k++) begin
      chk("b2b en",   32'(lcd_en),   32'(((k % 13) >= 2 && (k % 13) <= 4) ? 1 : 0));
      chk("b2b done", 32'(done),     32'(((k % 13) == 12) ? 1 : 0));
      chk("b2b busy", 32'(busy),     32'd1);
      chk("b2b data", 32'(lcd_data), 32'h30);
      if (k == 38) start = 1'b0;
      if (k < 38) tick();
    end
    tick();
    chk("b2b end busy", 32'(busy), 32'd0);
    chk("b2b end done", 32'(done), 32'd0);

    // Start pulses sampled mid-transaction (edges 3,6,9,12) must be ignored.
    data_in = 8'h5A;
    rs_in   = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      chk("ign en",   32'(lcd_en), 32'((k >= 2 && k <= 4) ? 1 : 0));
      chk("ign done", 32'(done),   32'((k == 12) ? 1 : 0));
      chk("ign busy", 32'(busy),   32'((k <= 12) ? 1 : 0));
      start = (k == 2 || k == 5 || k == 8 || k == 11);
      if (k < 20) tick();
    end
    start = 1'b0;

    // Reset while EN is high: EN must drop before the next edge, no done afterwards.
    data_in = 8'h55;
    rs_in   = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst en_before", 32'(lcd_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst en_async", 32'(lcd_en), 32'd0);
    chk("midrst busy",     32'(busy),   32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("midrst no_done", 32'(done),   32'd0);
      chk("midrst no_en",   32'(lcd_en), 32'd0);
    end
    run_txn(8'h66, 1'b1, 12, 1'b0, "after_rst");

    // Input churn during a transaction must not reach the bus.
    run_txn(8'hA5, 1'b0, 12, 1'b1, "stable");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
